// File: rtl/ha_array_row_accumulator.sv
// Multi-cycle reducer: captures the four half-adder row pairs, sums ROWS_PER_CYCLE
// shifted rows per cycle into a wrapping accumulator, then offers the product.
module ha_array_row_accumulator #(
   parameter int PROD_W         = 16,
   parameter int ROWS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        ha_array_0_b,
   input  logic [8:0]        ha_array_0_t,
   input  logic [6:0]        ha_array_1_b,
   input  logic [8:0]        ha_array_1_t,
   input  logic [6:0]        ha_array_2_b,
   input  logic [8:0]        ha_array_2_t,
   input  logic [6:0]        ha_array_3_b,
   input  logic [8:0]        ha_array_3_t,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              out_ovf
);

   localparam int         NROWS    = 4;
   localparam logic [1:0] CNT_STEP = 2'(ROWS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(NROWS - ROWS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t              state_reg, state_next;
   logic [1:0]          cnt_reg, cnt_next;
   logic [PROD_W-1:0]   acc_reg, acc_next;
   logic                ovf_reg, ovf_next;
   logic [PROD_W-1:0]   product_reg, product_next;
   logic                out_ovf_reg, out_ovf_next;
   logic                capture;

   logic [6:0]          b_in  [NROWS];
   logic [8:0]          t_in  [NROWS];
   logic [6:0]          b_reg [NROWS];
   logic [8:0]          t_reg [NROWS];
   logic [9:0]          row_val  [NROWS];
   logic [15:0]         row_wide [NROWS];
   logic [PROD_W-1:0]   row_term [NROWS];

   logic [PROD_W-1:0]   acc_chain;
   logic                ovf_chain;
   logic [PROD_W:0]     sum;
   logic [1:0]          idx;

   assign b_in[0] = ha_array_0_b;
   assign b_in[1] = ha_array_1_b;
   assign b_in[2] = ha_array_2_b;
   assign b_in[3] = ha_array_3_b;
   assign t_in[0] = ha_array_0_t;
   assign t_in[1] = ha_array_1_t;
   assign t_in[2] = ha_array_2_t;
   assign t_in[3] = ha_array_3_t;

   // Per-row capture and row weighting: R_k = t + 4*b, placed at bit 2k.
   generate
      for (genvar gi = 0; gi < NROWS; gi++) begin : g_row
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b_reg[gi] <= '0;
               t_reg[gi] <= '0;
            end else if (capture) begin
               b_reg[gi] <= b_in[gi];
               t_reg[gi] <= t_in[gi];
            end
         end

         assign row_val[gi]  = 10'(t_reg[gi]) + {1'b0, b_reg[gi], 2'b00};
         assign row_wide[gi] = {6'b0, row_val[gi]} << (2 * gi);
         assign row_term[gi] = PROD_W'(row_wide[gi]);
      end
   endgenerate

   // Chained PROD_W+1 bit adders; any carry out of the top bit sets the sticky flag.
   always_comb begin
      acc_chain = acc_reg;
      ovf_chain = ovf_reg;
      sum       = '0;
      idx       = '0;
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
         idx       = cnt_reg + 2'(j);
         sum       = {1'b0, acc_chain} + {1'b0, row_term[idx]};
         ovf_chain = ovf_chain | sum[PROD_W];
         acc_chain = sum[PROD_W-1:0];
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      ovf_next     = ovf_reg;
      product_next = product_reg;
      out_ovf_next = out_ovf_reg;
      capture      = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture    = 1'b1;
               acc_next   = '0;
               ovf_next   = 1'b0;
               cnt_next   = '0;
               state_next = ACC;
            end
         end
         ACC: begin
            acc_next = acc_chain;
            ovf_next = ovf_chain;
            cnt_next = cnt_reg + CNT_STEP;
            // Publish on the final add so product is valid as soon as OUT is entered.
            if (cnt_reg == LAST_CNT) begin
               product_next = acc_chain;
               out_ovf_next = ovf_chain;
               state_next   = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         ovf_reg     <= 1'b0;
         product_reg <= '0;
         out_ovf_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         ovf_reg     <= ovf_next;
         product_reg <= product_next;
         out_ovf_reg <= out_ovf_next;
      end
   end

   assign product = product_reg;
   assign out_ovf = out_ovf_reg;

endmodule
